// File: rtl/uart_boot_ctrl.sv
// rtl/uart_boot_ctrl.sv - UART boot loader: parses a framed image into instruction memory and gates the core
module uart_boot_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter int          TIMEOUT   = 100000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_ready,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_load_busy,
    output logic              o_load_error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_ACK  = 3'd5;
    localparam logic [2:0] S_RUN  = 3'd6;

    localparam logic [7:0] ACK_K = 8'h4B;
    localparam logic [7:0] ACK_E = 8'h45;
    localparam logic [7:0] ACK_L = 8'h4C;
    localparam logic [7:0] ACK_T = 8'h54;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]        r_state;
    logic [7:0]        r_csum;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic [CNT_W-1:0]  r_idle_cnt;

    logic [2:0]  w_next;
    logic [7:0]  w_ack_code;
    logic        w_start;
    logic [15:0] w_len;
    logic        w_in_frame;
    logic        w_timeout;

    assign w_len      = {i_rx_data, r_len_lo};
    assign w_in_frame = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout  = w_in_frame && !i_rx_valid &&
                        (r_idle_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state decode and selection of the ack code for the frame being closed.
    always_comb begin
        w_next     = r_state;
        w_ack_code = ACK_K;
        w_start    = 1'b0;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
                    w_next  = S_LEN0;
                    w_start = 1'b1;
                end
            end
            S_LEN0: if (i_rx_valid) w_next = S_LEN1;
            S_LEN1: begin
                if (i_rx_valid) begin
                    if (w_len == 16'd0 || 32'(w_len) > DEPTH) begin
                        w_next     = S_ACK;
                        w_ack_code = ACK_L;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (i_rx_valid && r_byte_idx == 2'd3 &&
                    (32'(r_word_idx) + 32'd1) == 32'(r_len))
                    w_next = S_CSUM;
            end
            S_CSUM: begin
                if (i_rx_valid) begin
                    w_next     = S_ACK;
                    w_ack_code = (i_rx_data == r_csum) ? ACK_K : ACK_E;
                end
            end
            S_ACK: begin
                if (i_tx_ready) w_next = (o_tx_data == ACK_K) ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next     = S_ACK;
            w_ack_code = ACK_T;
        end
    end

    // Frame datapath, registered outputs and state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_csum       <= 8'd0;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_idx   <= '0;
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_idle_cnt   <= '0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= 8'd0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= 32'd0;
            o_cpu_hold   <= 1'b1;
            o_load_busy  <= 1'b0;
            o_load_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            o_imem_we   <= 1'b0;
            o_cpu_hold  <= (w_next != S_RUN);
            o_load_busy <= (w_next != S_IDLE) && (w_next != S_RUN);

            if (i_rx_valid || !w_in_frame)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;

            if (w_start) begin
                r_csum       <= 8'd0;
                r_byte_idx   <= 2'd0;
                r_word_idx   <= '0;
                o_load_error <= 1'b0;
            end

            if (i_rx_valid) begin
                case (r_state)
                    S_LEN0: begin
                        r_len_lo <= i_rx_data;
                        r_csum   <= r_csum ^ i_rx_data;
                    end
                    S_LEN1: begin
                        r_len  <= w_len;
                        r_csum <= r_csum ^ i_rx_data;
                    end
                    S_DATA: begin
                        // Little-endian: bytes shift in from the top so byte0 ends up in [7:0].
                        r_csum     <= r_csum ^ i_rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word     <= {i_rx_data, r_word[23:8]};
                        if (r_byte_idx == 2'd3) begin
                            o_imem_we    <= 1'b1;
                            o_imem_addr  <= r_word_idx;
                            o_imem_wdata <= {i_rx_data, r_word};
                            r_word_idx   <= r_word_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_next == S_ACK && r_state != S_ACK) begin
                o_tx_valid <= 1'b1;
                o_tx_data  <= w_ack_code;
            end

            if (r_state == S_ACK && i_tx_ready) begin
                o_tx_valid <= 1'b0;
                if (o_tx_data != ACK_K) o_load_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_boot_ctrl.md
# uart_boot_ctrl

Boot-load controller between the UART byte interface and the pipeline's instruction memory. It holds the RISC-V core in stall and parses a framed program image arriving over UART RX. It writes the image word by word into instruction memory, acknowledges the frame over UART TX, and releases the core only after a frame passes its checks. A sync byte received while the core runs re-enters load mode, so the core can be reprogrammed without a chip reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2^ADDR_W words
- TIMEOUT, 100000, maximum idle cycles allowed between bytes inside a frame
- SYNC_BYTE, 8'hA5, frame start byte
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received UART byte
- tx_ready  in  1  UART TX can accept a byte this cycle
- tx_valid  out  1  ack byte pending
- tx_data  out  8  ack byte
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  32  write data
- cpu_hold  out  1  1 = core stalled/held in reset
- load_busy  out  1  1 while a frame is being received or acked
- load_error  out  1  sticky: last frame failed

## Operation
- Frame: SYNC_BYTE, LEN_LO, LEN_HI (word count N, 16-bit LE), 4·N data bytes (each word LE, byte0 first), CSUM. CSUM = XOR of LEN_LO, LEN_HI and all data bytes.
- States: IDLE, LEN0, LEN1, DATA, CSUM, ACK, RUN.
- IDLE: rx_valid with SYNC_BYTE -> LEN0; clear checksum, byte index, word address; clear load_error. Other bytes are ignored.
- LEN0/LEN1: latch length bytes and fold them into the checksum. After LEN1:
  - N==0 or N>DEPTH -> ACK with 'L' (8'h4C).
  - Otherwise -> DATA.
- DATA: shift each byte into a word register at byte lane = byte index. The byte that completes a word triggers a write on the next cycle: imem_we=1, imem_addr=word index, imem_wdata=assembled word. The word index then increments. After word N-1 the state -> CSUM.
- CSUM: received byte == running XOR -> ACK with 'K' (8'h4B); mismatch -> ACK with 'E' (8'h45).
- Timeout: an idle counter resets on every rx_valid. In LEN0..CSUM, reaching TIMEOUT-1 cycles without a byte -> ACK with 'T' (8'h54).
- ACK: tx_valid=1 with tx_data stable until a cycle where tx_ready=1. After that transfer:
  - 'K' -> RUN.
  - Any other code -> IDLE with load_error=1.
  - rx bytes arriving during ACK are dropped.
- RUN: cpu_hold=0. rx_valid with SYNC_BYTE -> cpu_hold=1 on the next cycle and the state goes to LEN0. Other bytes are ignored; they belong to the running program.
- cpu_hold = 0 only in RUN. Failed frames leave memory partially written and the core held.
- load_busy = 1 in LEN0, LEN1, DATA, CSUM, ACK.

## Timing
- Reset values (async, immediate): state IDLE, cpu_hold=1, tx_valid=0, tx_data=0, imem_we=0, imem_addr=0, imem_wdata=0, load_busy=0, load_error=0, idle counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Write latency: imem_we is asserted exactly 1 cycle after the rx_valid of a word's 4th byte, for exactly 1 cycle.
- tx_valid is asserted 1 cycle after the terminating event (CSUM byte, bad length, or timeout). tx_valid deasserts the cycle after the tx_ready transfer.
- cpu_hold falls 1 cycle after the 'K' transfer. It rises 1 cycle after a SYNC_BYTE is seen in RUN.
- Timeout and rx_valid in the same cycle: the byte wins and the counter clears.
- Reset asserted mid-frame: abort immediately to reset values, with no ack. Memory contents are untouched beyond writes already issued.

## Test plan
- Good load: A5 02 00 13 00 00 00 93 00 10 00 92 -> imem writes (0, 0x00000013) then (1, 0x00100093); tx 0x4B; cpu_hold falls after ack; load_error=0.
- Checksum error: same frame with CSUM 0x00 -> both writes occur; tx 0x45; cpu_hold stays 1; load_error=1.
- Bad length: A5 00 00 -> no writes; tx 0x4C. Also A5 01 01 with ADDR_W=8 (N=257) -> no writes; tx 0x4C.
- Timeout: A5 01 00 13, then silence for TIMEOUT cycles -> tx 0x54 on the cycle after cycle TIMEOUT-1; state returns to IDLE. Hold tx_ready=0 for 5 cycles -> tx_valid/tx_data stay stable throughout.
- Reprogram from RUN: after a good load, send bytes 0x41 (ignored, cpu_hold=0), then A5 01 00 EF BE AD DE <csum 0x01^0xEF^0xBE^0xAD^0xDE> -> cpu_hold rises 1 cycle after A5; write (0, 0xDEADBEEF); tx 0x4B; core released.
- Reset mid-DATA: assert rst after the 6th data byte -> outputs take reset values immediately, no tx; a subsequent good frame loads normally.
